fft_stage_seq: RTL and testbench
================================

Name: fft_stage_seq

Overview:
- Stage sequencer for the 16-lane radix-16 FFT datapath: IOBUF/FSC banks → interface mux → HRMF → interface mux → banks.
- On START it sweeps N_STAGES passes of ROWS rows each. Per row it issues a read address, datapath mux selects and a twiddle exponent base.
- It delays a write-enable/address copy by the HRMF pipeline latency so results land in place. It pulses DONE when the final pass has been written.

Parameters:
- N_STAGES, 3, number of radix-16 passes (4096 points).
- ROWS, 256, rows per pass (points / 16 lanes).
- PIPE_LAT, 6, cycles from read address issue to HRMF result valid at bank D inputs; must be ≥1.
- AW, 12, bank address width.

Ports:
- CLK  in  1  clock, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- START  in  1  begin transform; sampled only in IDLE.
- DONE  out  1  one-cycle pulse after the last write.
- BUSY  out  1  high in every state except IDLE.
- STAGE  out  2  current read pass index.
- RD_ADDR  out  AW  row address to all 16 read ports.
- WR_ADDR  out  AW  row address to all 16 write ports.
- WE_FSC  out  1  FSC write enable.
- WE_IOBUF  out  1  IOBUF write enable.
- SEL_ITR  out  1  read source: 0 = IOBUF, 1 = FSC.
- SEL_PERMR  out  4  read-side lane permutation select.
- SEL_PERMW  out  4  write-side lane permutation select.
- EXP_BASE  out  16  twiddle exponent base for the row.

Behaviour:
- All outputs registered. Reset (async, RSTn=0) forces state IDLE and every output to 0; counters and delay line also clear.
- States: IDLE, READ, DRAIN, FINISH.
- IDLE: START=1 → READ next cycle with stage=0, row=0. START is ignored in all other states.
- READ:
  - One row issued per cycle: RD_ADDR=row, SEL_ITR=(stage!=0), SEL_PERMR=(row+stage) mod 16.
  - EXP_BASE=({4'b0,row}<<(4*stage)) mod 2^16, forced to 0 when stage=N_STAGES-1.
  - The row counter increments every cycle. At row=ROWS-1 → DRAIN.
- DRAIN:
  - Lasts exactly PIPE_LAT cycles; no reads issued; RD_ADDR holds its last value.
  - At the end: if stage<N_STAGES-1, stage increments and row returns to 0, then → READ with no bubble. Otherwise → FINISH.
- FINISH: DONE=1 for one cycle, then IDLE. BUSY=0 from the IDLE cycle onward.
- Write delay line, PIPE_LAT deep, carries {valid, row, stage}:
  - WR_ADDR = delayed row.
  - SEL_PERMW = (delayed row + delayed stage) mod 16.
  - WE_FSC = valid when delayed stage<N_STAGES-1.
  - WE_IOBUF = valid when delayed stage=N_STAGES-1.
  - WE_FSC and WE_IOBUF are never both 1.
- In-place: a pass's last write occurs in the final DRAIN cycle, strictly before the next pass's first read of the same bank.
- Total START-sample → DONE = N_STAGES*(ROWS+PIPE_LAT)+1 cycles. With defaults, DONE is high in cycle 787 after the START edge.
- Reset mid-operation: immediate return to IDLE, delay line flushed, no further WE. A new START restarts from stage 0.
- STAGE holds its value through DRAIN and FINISH, and returns to 0 in IDLE.

Optional Feature:
- Macro FFT_SEQ_HOLD_EN.
- Defined: adds input HOLD (1 bit).
  - HOLD=1 in READ freezes row, RD_ADDR and EXP_BASE, and pushes valid=0 into the delay line.
  - The write side keeps draining, and DRAIN/FINISH ignore HOLD.
  - Latency grows by the number of held READ cycles.
- Undefined: no HOLD port; READ never stalls.

Test Plan:
- Reset then START=1 for one cycle, defaults → BUSY rises next cycle; STAGE goes 0→1→2 at READ entries; DONE pulses exactly at cycle 787; BUSY=0 in cycle 788.
- Address trace, stage 1 → RD_ADDR 0..255 consecutive with SEL_ITR=1; WR_ADDR equals RD_ADDR delayed 6 cycles; exactly 256 WE_FSC pulses in the pass; WE_IOBUF=0.
- Final stage → exactly 256 WE_IOBUF pulses; WE_FSC=0; EXP_BASE=0 throughout; row 5 of stage 1 shows EXP_BASE=0x0050 and SEL_PERMR=6.
- START pulsed during READ of stage 1 → ignored; only one DONE pulse; total 787 cycles unchanged.
- RSTn=0 at row 100 of stage 1 → all outputs 0 asynchronously; after release with START low, no WE asserts; a new START completes in 787 cycles.
- FFT_SEQ_HOLD_EN defined, HOLD high for 10 cycles at stage 0 row 50 → row 50 repeated with no WE generated for it; WE gap of 10 cycles appears 6 cycles later; DONE at cycle 797.

Source files
------------

// File: rtl/fft_stage_seq.sv
// fft_stage_seq: row/pass sequencer for the radix-16 FFT banks; optional read stall via FFT_SEQ_HOLD_EN
module fft_stage_seq #(
  parameter int N_STAGES = 3,
  parameter int ROWS     = 256,
  parameter int PIPE_LAT = 6,
  parameter int AW       = 12
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
`ifdef FFT_SEQ_HOLD_EN
  input  logic          i_hold,
`endif
  output logic          o_done,
  output logic          o_busy,
  output logic [1:0]    o_stage,
  output logic [AW-1:0] o_rd_addr,
  output logic [AW-1:0] o_wr_addr,
  output logic          o_we_fsc,
  output logic          o_we_iobuf,
  output logic          o_sel_itr,
  output logic [3:0]    o_sel_permr,
  output logic [3:0]    o_sel_permw,
  output logic [15:0]   o_exp_base
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;
  localparam int CW = $clog2(PIPE_LAT) + 1;
  localparam logic [1:0] LAST = 2'(N_STAGES - 1);
  typedef struct packed {
    logic          fsc;
    logic          iob;
    logic [3:0]    perm;
    logic [AW-1:0] addr;
  } wr_t;
  state_t        r_state, w_state_n;
  logic [AW-1:0] r_row, w_row_n;
  logic [1:0]    r_stage, w_stage_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic          w_hold;
  logic          r_busy, r_done, r_rd_valid, r_sel_itr;
  logic [AW-1:0] r_rd_addr;
  logic [3:0]    r_sel_permr;
  logic [15:0]   r_exp_base;
  wr_t           r_dly [PIPE_LAT];
  wr_t           w_push;
`ifdef FFT_SEQ_HOLD_EN
  assign w_hold = i_hold;
`else
  assign w_hold = 1'b0;
`endif
  // state, row, pass and drain counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_stage <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_row   <= w_row_n;
      r_stage <= w_stage_n;
      r_cnt   <= w_cnt_n;
    end
  end
  // next-state: one row per READ cycle, PIPE_LAT drain cycles, then next pass or finish
  always_comb begin
    w_state_n = r_state;
    w_row_n   = r_row;
    w_stage_n = r_stage;
    w_cnt_n   = r_cnt;
    case (r_state)
      IDLE: if (i_start) begin
        w_state_n = READ;
        w_row_n   = '0;
        w_stage_n = '0;
      end
      READ: if (!w_hold) begin
        w_row_n = r_row + 1'b1;
        if (r_row == AW'(ROWS - 1)) begin
          w_state_n = DRAIN;
          w_cnt_n   = '0;
        end
      end
      DRAIN: if (r_cnt == CW'(PIPE_LAT - 1)) begin
        if (r_stage == LAST) w_state_n = FINISH;
        else begin
          w_state_n = READ;
          w_stage_n = r_stage + 1'b1;
          w_row_n   = '0;
        end
      end else w_cnt_n = r_cnt + 1'b1;
      FINISH: begin
        w_state_n = IDLE;
        w_stage_n = '0;
      end
      default: w_state_n = IDLE;
    endcase
  end
  // read-side outputs registered from next state so they line up with the state they describe
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_addr   <= '0;
      r_sel_itr   <= 1'b0;
      r_sel_permr <= '0;
      r_exp_base  <= '0;
    end else begin
      r_busy     <= w_state_n != IDLE;
      r_done     <= w_state_n == FINISH;
      r_rd_valid <= w_state_n == READ;
      if (w_state_n == READ) begin
        r_rd_addr   <= w_row_n;
        r_sel_itr   <= w_stage_n != 2'd0;
        r_sel_permr <= w_row_n[3:0] + {2'b00, w_stage_n};
        r_exp_base  <= (w_stage_n == LAST) ? 16'd0 : (16'(w_row_n) << (4 * w_stage_n));
      end
    end
  end
  // write request for the row issued this cycle; held cycles push an empty slot
  always_comb begin
    w_push.fsc  = r_rd_valid && !w_hold && (r_stage != LAST);
    w_push.iob  = r_rd_valid && !w_hold && (r_stage == LAST);
    w_push.perm = r_rd_addr[3:0] + {2'b00, r_stage};
    w_push.addr = r_rd_addr;
  end
  // delay line matching the HRMF latency so results write back to the row they came from
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) r_dly[i] <= '0;
    end else begin
      r_dly[0] <= w_push;
      for (int i = 1; i < PIPE_LAT; i++) r_dly[i] <= r_dly[i-1];
    end
  end
  assign o_done      = r_done;
  assign o_busy      = r_busy;
  assign o_stage     = r_stage;
  assign o_rd_addr   = r_rd_addr;
  assign o_sel_itr   = r_sel_itr;
  assign o_sel_permr = r_sel_permr;
  assign o_exp_base  = r_exp_base;
  assign o_wr_addr   = r_dly[PIPE_LAT-1].addr;
  assign o_sel_permw = r_dly[PIPE_LAT-1].perm;
  assign o_we_fsc    = r_dly[PIPE_LAT-1].fsc;
  assign o_we_iobuf  = r_dly[PIPE_LAT-1].iob;
endmodule

// File: tb/tb_fft_stage_seq.sv
// tb_fft_stage_seq: cycle-by-cycle check of fft_stage_seq against a pass/row schedule model
module tb_fft_stage_seq;
  localparam int L = 6;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, hold = 1'b0;
  logic o_done, o_busy, o_we_fsc, o_we_iobuf, o_sel_itr;
  logic [1:0] o_stage;
  logic [11:0] o_rd_addr, o_wr_addr;
  logic [3:0] o_sel_permr, o_sel_permw;
  logic [15:0] o_exp_base;
  int errors = 0, checks = 0;

  typedef struct packed {
    logic busy, done;
    logic [1:0] stage;
    logic [11:0] rd;
    logic itr;
    logic [3:0] pr;
    logic [15:0] ex;
    logic fsc, iob;
    logic [11:0] wa;
    logic [3:0] pw;
  } snap_t;

  snap_t m [0:1023];
  bit inread [0:1023], indrain [0:1023], rv [0:1023];
  int mrow [0:1023], mst [0:1023];
  int total;

  fft_stage_seq dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
`ifdef FFT_SEQ_HOLD_EN
    .i_hold(hold),
`endif
    .o_done(o_done), .o_busy(o_busy), .o_stage(o_stage),
    .o_rd_addr(o_rd_addr), .o_wr_addr(o_wr_addr),
    .o_we_fsc(o_we_fsc), .o_we_iobuf(o_we_iobuf),
    .o_sel_itr(o_sel_itr), .o_sel_permr(o_sel_permr),
    .o_sel_permw(o_sel_permw), .o_exp_base(o_exp_base)
  );

  always #5 clk = ~clk;

  function automatic void rd_cycle(int c, int s, int r, bit v);
    m[c].busy = 1'b1;
    m[c].stage = 2'(s);
    m[c].rd = 12'(r);
    m[c].itr = s != 0;
    m[c].pr = 4'((r + s) % 16);
    m[c].ex = (s == 2) ? 16'd0 : 16'((r << (4 * s)) % 65536);
    inread[c] = 1'b1;
    rv[c] = v;
    mrow[c] = r;
    mst[c] = s;
  endfunction

  // cycle c = the c-th cycle after the START sampling edge
  function automatic void build(int hs, int hl);
    int c = 1;
    for (int i = 0; i < 1024; i++) begin
      m[i] = '0; inread[i] = 0; indrain[i] = 0; rv[i] = 0; mrow[i] = 0; mst[i] = 0;
    end
    for (int s = 0; s < 3; s++) begin
      for (int r = 0; r < 256; r++) begin
        while (c >= hs && c < hs + hl) begin rd_cycle(c, s, r, 1'b0); c++; end
        rd_cycle(c, s, r, 1'b1);
        c++;
      end
      for (int d = 0; d < L; d++) begin
        m[c].busy = 1'b1; m[c].stage = 2'(s); m[c].rd = 12'd255; indrain[c] = 1'b1; c++;
      end
    end
    m[c].busy = 1'b1; m[c].done = 1'b1; m[c].stage = 2'd2;
    total = c;
    for (int k = L + 1; k < 1024; k++) if (rv[k-L]) begin
      m[k].fsc = mst[k-L] < 2;
      m[k].iob = mst[k-L] == 2;
      m[k].wa = 12'(mrow[k-L]);
      m[k].pw = 4'((mrow[k-L] + mst[k-L]) % 16);
    end
  endfunction

  task automatic run(input string nm, input int hs, input int hl, input int stray, input int stop,
                     output int done_at, output int n_fsc, output int n_iob, output int n_done);
    snap_t o;
    int last;
    build(hs, hl);
    last = (stop > 0) ? stop : total + 4;
    done_at = -1; n_fsc = 0; n_iob = 0; n_done = 0;
    @(negedge clk); start = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      start = (c == stray);
      hold = (c >= hs && c < hs + hl);
      o = '0;
      o.busy = o_busy; o.done = o_done; o.stage = o_stage;
      if (inread[c] || indrain[c]) o.rd = o_rd_addr;
      if (inread[c]) begin o.itr = o_sel_itr; o.pr = o_sel_permr; o.ex = o_exp_base; end
      o.fsc = o_we_fsc; o.iob = o_we_iobuf;
      if (m[c].fsc || m[c].iob) begin o.wa = o_wr_addr; o.pw = o_sel_permw; end
      checks++;
      if (o !== m[c]) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", nm, c, o, m[c]);
      end
      if (o_done) begin n_done++; if (done_at < 0) done_at = c; end
      n_fsc += int'(o_we_fsc);
      n_iob += int'(o_we_iobuf);
    end
    start = 1'b0; hold = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_done, o_busy, o_stage, o_rd_addr, o_wr_addr, o_we_fsc, o_we_iobuf, o_sel_itr,
         o_sel_permr, o_sel_permw, o_exp_base} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs, expected all 0");
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_busy, o_we_fsc, o_we_iobuf, o_done} !== 4'b0) begin
      errors++; $display("FAIL reset_idle: got %b expected 0000", {o_busy, o_we_fsc, o_we_iobuf, o_done});
    end
  endtask

  task automatic test_full_run;
    int d, f, i, n;
    run("full_run", 0, 0, 0, 0, d, f, i, n);
    checks++; if (d !== 787) begin errors++; $display("FAIL full_done_cycle: got %0d expected 787", d); end
    checks++; if (n !== 1) begin errors++; $display("FAIL full_done_count: got %0d expected 1", n); end
    checks++; if (f !== 512) begin errors++; $display("FAIL full_we_fsc: got %0d expected 512", f); end
    checks++; if (i !== 256) begin errors++; $display("FAIL full_we_iobuf: got %0d expected 256", i); end
  endtask

  task automatic test_start_ignored;
    int d, f, i, n;
    repeat ($urandom_range(1, 5)) @(negedge clk);
    run("start_ignored", 0, 0, 263 + $urandom_range(0, 255), 0, d, f, i, n);
    checks++; if (d !== 787) begin errors++; $display("FAIL stray_done_cycle: got %0d expected 787", d); end
    checks++; if (n !== 1) begin errors++; $display("FAIL stray_done_count: got %0d expected 1", n); end
  endtask

  task automatic test_reset_midrun;
    int d, f, i, n;
    run("midrun_pre", 0, 0, 0, 263 + $urandom_range(20, 235), d, f, i, n);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_done, o_busy, o_stage, o_rd_addr, o_wr_addr, o_we_fsc, o_we_iobuf, o_sel_itr,
         o_sel_permr, o_sel_permw, o_exp_base} !== '0) begin
      errors++; $display("FAIL midrun_async_clear: got nonzero outputs, expected all 0");
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if ({o_busy, o_we_fsc, o_we_iobuf} !== 3'b0) begin
        errors++; $display("FAIL midrun_quiet cycle %0d: got %b expected 000", c, {o_busy, o_we_fsc, o_we_iobuf});
      end
    end
    run("midrun_restart", 0, 0, 0, 0, d, f, i, n);
    checks++; if (d !== 787) begin errors++; $display("FAIL restart_done_cycle: got %0d expected 787", d); end
  endtask

`ifdef FFT_SEQ_HOLD_EN
  task automatic test_hold;
    int d, f, i, n;
    run("hold", 51, 10, 0, 0, d, f, i, n);
    checks++; if (d !== 797) begin errors++; $display("FAIL hold_done_cycle: got %0d expected 797", d); end
    checks++; if (f !== 512) begin errors++; $display("FAIL hold_we_fsc: got %0d expected 512", f); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_run();
    test_start_ignored();
    test_reset_midrun();
`ifdef FFT_SEQ_HOLD_EN
    test_hold();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
